flash_read_cache: RTL and testbench
===================================

// Module: flash_read_cache
// PURPOSE
//  Direct-mapped, read-only word cache between the CPU memory bus (SPI page, already
//  qualified by the address decode) and the spi_flash word reader. A hit returns data with
//  no busy cycles. A miss issues exactly one spi_flash word read and fills the line.
//  This removes the multi-cycle SPI latency on repeated fetches from code and constants
//  held in flash.
// PARAMETERS
//  LINES   16  number of one-word lines; power of two, 2..2**ADDR_W
//  ADDR_W  15  word-address width; matches the spi_flash word_address port
//  IDX_W   $clog2(LINES)  derived (localparam); TAG_W = ADDR_W-IDX_W
// PORTS
//  clk                 in   1       system clock; all logic rising-edge
//  reset_n             in   1       asynchronous, active-low reset
//  cpu_rstrb           in   1       one-cycle read strobe (SPI-page qualified)
//  cpu_word_address    in   ADDR_W  word address, valid in the cpu_rstrb cycle
//  cpu_rdata           out  32      read data; held until the next read completes
//  cpu_rbusy           out  1       high while a miss is outstanding
//  flash_rstrb         out  1       one-cycle read strobe to spi_flash
//  flash_word_address  out  ADDR_W  address to spi_flash; held through the fill
//  flash_rdata         in   32      spi_flash read data
//  flash_rbusy         in   1       spi_flash busy
//  invalidate          in   1       clear all valid bits (e.g. after flash reprogram)
//  stat_hits           out  16      saturating hit counter
// BEHAVIOUR
//  - Reset, async on reset_n low:
//    - cpu_rdata=0, cpu_rbusy=0, flash_rstrb=0, flash_word_address=0, stat_hits=0.
//    - All valid bits cleared; state=IDLE.
//    - Data and tag arrays are not cleared.
//  - Bus protocol, identical on both sides:
//    - rstrb is a single-cycle pulse.
//    - Data is valid in the first cycle after rstrb in which rbusy is low.
//  - Lookup: idx=addr[IDX_W-1:0], tag=addr[ADDR_W-1:IDX_W].
//    - Arrays are read asynchronously (flop arrays).
//    - Hit = valid[idx] & tag match & !invalidate.
//  - FSM IDLE -> REQ -> WAIT -> IDLE.
//  - IDLE, cpu_rstrb in cycle N:
//    - Hit: at edge N -> cpu_rdata<=data[idx], cpu_rbusy stays 0, stat_hits++ (sat 16'hFFFF).
//    - Miss: at edge N -> cpu_rbusy<=1, flash_word_address<=addr, latch idx/tag, ->REQ.
//  - REQ: flash_rstrb=1 for exactly this cycle; ->WAIT.
//  - WAIT: any cycle with flash_rbusy=0 is the data cycle M.
//    - The cycle directly after REQ counts.
//    - At edge M: cpu_rdata<=flash_rdata, cpu_rbusy<=0, data/tag[idx]<=value/tag.
//    - valid[idx]<=1 unless invalidate was seen during this miss; ->IDLE.
//  - Latency:
//    - Hit: data at N+1.
//    - Miss: flash_rstrb at N+1, data at M+1 (M >= N+2).
//  - invalidate:
//    - Clears every valid bit at the next edge, in any state.
//    - A lookup in the same cycle is a forced miss.
//    - An in-flight fill still returns data to the CPU but leaves the line invalid.
//  - cpu_rstrb outside IDLE is ignored; the CPU never issues it while cpu_rbusy=1.
//  - flash_rbusy is ignored outside WAIT.
//  - A stale spi_flash transfer after reset is not tracked.
//  - Only one miss is ever outstanding; no write path exists (flash is read-only here).
//  - Index wrap: addresses differing only in tag bits evict each other; no other aliasing.
// TESTING
//  1. Reset; cpu read 0x0010; flash model busy 40 cycles, returns 32'hDEADBEEF.
//     -> one flash_rstrb pulse with address 0x0010.
//     -> cpu_rbusy=1 through the fill; cpu_rdata=DEADBEEF and rbusy=0 the cycle after flash_rbusy falls.
//  2. Re-read 0x0010 -> no flash_rstrb; cpu_rbusy never high; DEADBEEF at N+1; stat_hits=1.
//  3. LINES=16: read 0x0020 (index 0, data 0x11111111), then 0x0010 -> both miss.
//     -> 0x0010 refetched, returns DEADBEEF; 0x0020 then misses again.
//  4. Miss on 0x0030 with invalidate pulsed mid-WAIT -> CPU gets the flash data.
//     -> Immediate re-read of 0x0030 misses; earlier cached 0x0010 also misses.
//  5. reset_n low during WAIT -> outputs take reset values without a clock edge.
//     -> After release, a read of 0x0010 misses.
//  6. Force 70000 consecutive hits -> stat_hits stops at 16'hFFFF, does not wrap.

Source files
------------

// File: rtl/flash_read_cache.sv
// flash_read_cache: direct-mapped, read-only, one-word-per-line cache sitting
// between the CPU memory bus and the spi_flash word reader. Hits complete with
// no busy cycles; a miss issues a single spi_flash read and fills the line.
//
// state  | meaning
// IDLE   | accepting CPU reads; hits answered at the strobe edge
// REQ    | flash_rstrb high for this one cycle
// WAIT   | waiting for spi_flash; first cycle with flash_rbusy low fills the line
module flash_read_cache #(
  parameter int LINES  = 16,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_rstrb,
  input  logic [ADDR_W-1:0] cpu_word_address,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_rbusy,
  output logic              flash_rstrb,
  output logic [ADDR_W-1:0] flash_word_address,
  input  logic [31:0]       flash_rdata,
  input  logic              flash_rbusy,
  input  logic              invalidate,
  output logic [15:0]       stat_hits
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t            state_q;
  logic [31:0]       cpu_rdata_q;
  logic              cpu_rbusy_q;
  logic              flash_rstrb_q;
  logic [ADDR_W-1:0] flash_addr_q;
  logic [15:0]       stat_hits_q;

  // Line storage: data and tags are not reset, only the valid bits are.
  logic [31:0]       data_q [LINES];
  logic [TAG_W-1:0]  tag_arr_q [LINES];
  logic [LINES-1:0]  valid_q;

  // Miss context held from the strobe edge until the fill.
  logic [IDX_W-1:0]  idx_q;
  logic [TAG_W-1:0]  tag_q;
  logic              inv_seen_q;

  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic              hit;
  logic              fill;

  assign lk_idx = cpu_word_address[IDX_W-1:0];
  assign lk_tag = cpu_word_address[ADDR_W-1:IDX_W];

  // An invalidate in the lookup cycle forces a miss, even on a matching line.
  assign hit  = valid_q[lk_idx] && (tag_arr_q[lk_idx] == lk_tag) && !invalidate;
  assign fill = (state_q == S_WAIT) && !flash_rbusy;

  assign cpu_rdata          = cpu_rdata_q;
  assign cpu_rbusy          = cpu_rbusy_q;
  assign flash_rstrb        = flash_rstrb_q;
  assign flash_word_address = flash_addr_q;
  assign stat_hits          = stat_hits_q;

  // Lookup/fill sequencer with registered bus outputs, valid bits and hit counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cpu_rdata_q   <= '0;
      cpu_rbusy_q   <= 1'b0;
      flash_rstrb_q <= 1'b0;
      flash_addr_q  <= '0;
      stat_hits_q   <= '0;
      valid_q       <= '0;
      idx_q         <= '0;
      tag_q         <= '0;
      inv_seen_q    <= 1'b0;
    end else begin
      flash_rstrb_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cpu_rstrb) begin
            if (hit) begin
              cpu_rdata_q <= data_q[lk_idx];
              if (stat_hits_q != 16'hFFFF) begin
                stat_hits_q <= stat_hits_q + 16'd1;
              end
            end else begin
              cpu_rbusy_q   <= 1'b1;
              flash_addr_q  <= cpu_word_address;
              flash_rstrb_q <= 1'b1;
              idx_q         <= lk_idx;
              tag_q         <= lk_tag;
              // An invalidate that forced this miss still counts against the fill.
              inv_seen_q    <= invalidate;
              state_q       <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (invalidate) begin
            inv_seen_q <= 1'b1;
          end
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (invalidate) begin
            inv_seen_q <= 1'b1;
          end
          if (!flash_rbusy) begin
            cpu_rdata_q <= flash_rdata;
            cpu_rbusy_q <= 1'b0;
            if (!inv_seen_q && !invalidate) begin
              valid_q[idx_q] <= 1'b1;
            end
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
      // Clear-all takes precedence over any fill in the same cycle.
      if (invalidate) begin
        valid_q <= '0;
      end
    end
  end

  // Line data and tag written on the fill cycle; no reset needed since valid gates use.
  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[idx_q]    <= flash_rdata;
      tag_arr_q[idx_q] <= tag_q;
    end
  end

endmodule

// File: tb/tb_flash_read_cache.sv
// Directed bench for flash_read_cache with a behavioural spi_flash model.
module tb_flash_read_cache;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_rstrb;
  logic [14:0] cpu_word_address;
  logic [31:0] cpu_rdata;
  logic        cpu_rbusy;
  logic        flash_rstrb;
  logic [14:0] flash_word_address;
  logic [31:0] flash_rdata;
  logic        flash_rbusy;
  logic        invalidate;
  logic [15:0] stat_hits;

  int n_vec = 0;
  int n_err = 0;
  int exp_hits = 0;

  // spi_flash model state
  int          flash_lat = 40;
  int          fl_cnt = 0;
  int          n_fstrb = 0;
  logic [14:0] fl_addr = '0;
  time         t_fstrb = 0;
  time         t_fall = 0;

  always #5 clk = ~clk;

  flash_read_cache #(.LINES(16), .ADDR_W(15)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .cpu_rstrb          (cpu_rstrb),
    .cpu_word_address   (cpu_word_address),
    .cpu_rdata          (cpu_rdata),
    .cpu_rbusy          (cpu_rbusy),
    .flash_rstrb        (flash_rstrb),
    .flash_word_address (flash_word_address),
    .flash_rdata        (flash_rdata),
    .flash_rbusy        (flash_rbusy),
    .invalidate         (invalidate),
    .stat_hits          (stat_hits)
  );

  function automatic logic [31:0] fmem(input logic [14:0] a);
    case (a)
      15'h0010: return 32'hDEADBEEF;
      15'h0020: return 32'h11111111;
      15'h0030: return 32'h30303030;
      default:  return 32'hC0DE0000 | {17'd0, a};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Flash model: busy for flash_lat cycles after each strobe, then presents data.
  // t_fall marks the negedge opening the cycle in which the DUT should take the data.
  always @(negedge clk) begin
    if (!reset_n) begin
      fl_cnt      = 0;
      flash_rbusy = 1'b0;
    end else if (flash_rstrb) begin
      n_fstrb++;
      fl_addr = flash_word_address;
      t_fstrb = $time;
      if (flash_lat == 0) begin
        flash_rbusy = 1'b0;
        flash_rdata = fmem(flash_word_address);
        t_fall      = $time + 10;
      end else begin
        flash_rbusy = 1'b1;
        flash_rdata = 32'hBADC0FFE;
        fl_cnt      = flash_lat;
      end
    end else if (fl_cnt > 0) begin
      fl_cnt--;
      if (fl_cnt == 0) begin
        flash_rbusy = 1'b0;
        flash_rdata = fmem(fl_addr);
        t_fall      = $time;
      end
    end
  end

  // One CPU read; inv_now pulses invalidate in the strobe cycle.
  task automatic cpu_read(input logic [14:0] a, input bit exp_miss, input bit inv_now);
    int          n0;
    int          cyc;
    time         t0;
    logic [31:0] exp;
    exp = fmem(a);
    n0  = n_fstrb;
    @(negedge clk);
    cpu_rstrb        = 1'b1;
    cpu_word_address = a;
    invalidate       = inv_now;
    t0               = $time;
    @(negedge clk);
    cpu_rstrb        = 1'b0;
    invalidate       = 1'b0;
    cpu_word_address = 15'h7FFF;
    if (!exp_miss) begin
      exp_hits++;
      chk("hit_busy", 32'(cpu_rbusy), 0);
      chk("hit_data", cpu_rdata, exp);
      chk("hit_count", 32'(stat_hits), 32'(exp_hits));
      @(negedge clk);
      chk("hit_no_flash_strobe", n_fstrb - n0, 0);
      chk("hit_busy_after", 32'(cpu_rbusy), 0);
    end else begin
      chk("miss_busy", 32'(cpu_rbusy), 1);
      cyc = 0;
      while (cpu_rbusy && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
      chk("miss_done_in_time", 32'(cpu_rbusy), 0);
      chk("miss_data", cpu_rdata, exp);
      chk("miss_flash_strobes", n_fstrb - n0, 1);
      chk("miss_flash_addr", 32'(fl_addr), 32'(a));
      chk("miss_strobe_latency", 32'(t_fstrb - t0), 10);
      chk("miss_data_latency", 32'($time - t_fall), 10);
      chk("miss_hit_count", 32'(stat_hits), 32'(exp_hits));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n          = 1'b0;
    cpu_rstrb        = 1'b0;
    cpu_word_address = '0;
    invalidate       = 1'b0;
    flash_rbusy      = 1'b0;
    flash_rdata      = '0;
    repeat (3) @(negedge clk);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_rbusy", 32'(cpu_rbusy), 0);
    chk("rst_flash_rstrb", 32'(flash_rstrb), 0);
    chk("rst_flash_addr", 32'(flash_word_address), 0);
    chk("rst_stat_hits", 32'(stat_hits), 0);
    reset_n = 1'b1;

    // Cold miss with a long flash latency, then a hit on the same word.
    flash_lat = 40;
    cpu_read(15'h0010, 1'b1, 1'b0);
    cpu_read(15'h0010, 1'b0, 1'b0);

    // Same-index eviction between 0x0020 and 0x0010.
    flash_lat = 3;
    cpu_read(15'h0020, 1'b1, 1'b0);
    cpu_read(15'h0010, 1'b1, 1'b0);
    cpu_read(15'h0020, 1'b1, 1'b0);

    // Different index does not alias; zero-latency flash exercises the first WAIT cycle.
    flash_lat = 0;
    cpu_read(15'h0015, 1'b1, 1'b0);
    cpu_read(15'h0015, 1'b0, 1'b0);
    cpu_read(15'h0020, 1'b0, 1'b0);

    // Invalidate in the lookup cycle forces a miss; the other line is cleared too.
    flash_lat = 1;
    cpu_read(15'h0015, 1'b1, 1'b1);
    cpu_read(15'h0020, 1'b1, 1'b0);
    cpu_read(15'h0015, 1'b1, 1'b0);
    cpu_read(15'h0010, 1'b1, 1'b0);

    // Invalidate mid-WAIT: data still returned, nothing stays cached.
    flash_lat = 20;
    fork
      cpu_read(15'h0030, 1'b1, 1'b0);
      begin
        repeat (8) @(negedge clk);
        invalidate = 1'b1;
        @(negedge clk);
        invalidate = 1'b0;
      end
    join
    flash_lat = 2;
    cpu_read(15'h0030, 1'b1, 1'b0);
    cpu_read(15'h0015, 1'b1, 1'b0);
    cpu_read(15'h0010, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a fill.
    flash_lat = 30;
    @(negedge clk);
    cpu_rstrb        = 1'b1;
    cpu_word_address = 15'h0040;
    @(negedge clk);
    cpu_rstrb        = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", 32'(cpu_rbusy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_rdata", cpu_rdata, 0);
    chk("async_rst_rbusy", 32'(cpu_rbusy), 0);
    chk("async_rst_flash_rstrb", 32'(flash_rstrb), 0);
    chk("async_rst_flash_addr", 32'(flash_word_address), 0);
    chk("async_rst_stat_hits", 32'(stat_hits), 0);
    exp_hits = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    flash_lat = 2;
    cpu_read(15'h0010, 1'b1, 1'b0);
    cpu_read(15'h0010, 1'b0, 1'b0);

    // Hit-counter saturation: strobe held high so every cycle is a hit lookup.
    @(negedge clk);
    cpu_word_address = 15'h0010;
    cpu_rstrb        = 1'b1;
    begin
      int n0;
      n0 = n_fstrb;
      repeat (65534 - exp_hits) @(negedge clk);
      chk("sat_fffe", 32'(stat_hits), 32'h0000FFFE);
      repeat (5) @(negedge clk);
      cpu_rstrb = 1'b0;
      chk("sat_ffff", 32'(stat_hits), 32'h0000FFFF);
      chk("sat_rdata", cpu_rdata, 32'hDEADBEEF);
      chk("sat_rbusy", 32'(cpu_rbusy), 0);
      chk("sat_no_flash", n_fstrb - n0, 0);
    end
    @(negedge clk);
    chk("sat_hold", 32'(stat_hits), 32'h0000FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
